// File: rtl/audio_mode_ctrl_if.sv
// Key, core-handshake and display signals of the audio recorder/player mode sequencer.
interface audio_mode_ctrl_if;
    logic       i_key_start;
    logic       i_key_pause;
    logic       i_key_stop;
    logic       i_sel_play;
    logic       i_done;
    logic [2:0] o_mode;
    logic       o_rec_en;
    logic       o_play_en;
    logic       o_clr;
    logic [5:0] o_sec;
    logic [5:0] o_rec_len;

    modport master (
        output i_key_start, i_key_pause, i_key_stop, i_sel_play, i_done,
        input  o_mode, o_rec_en, o_play_en, o_clr, o_sec, o_rec_len
    );

    modport slave (
        input  i_key_start, i_key_pause, i_key_stop, i_sel_play, i_done,
        output o_mode, o_rec_en, o_play_en, o_clr, o_sec, o_rec_len
    );
endinterface

// File: rtl/audio_mode_ctrl.sv
// Mode sequencer: key pulses -> one-hot mode, core enables, address clear and seconds count.
// Optional macro LOOP_PLAY_EN: i_done in PLAY restarts playback instead of returning to idle.
module audio_mode_ctrl #(
    parameter int unsigned CLK_FREQ = 12000000,
    parameter int unsigned MAX_SEC  = 32
) (
    input logic              i_clk,
    input logic              i_rst_n,
    audio_mode_ctrl_if.slave ctrl_io
);
    localparam int unsigned TickW   = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [TickW-1:0] TickMax = TickW'(CLK_FREQ - 1);
    localparam logic [5:0]       MaxSec  = 6'(MAX_SEC);

    typedef enum logic [2:0] {StIdle, StRec, StPlay, StPauseRec, StPausePlay} state_e;

    state_e           state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic             rec_en_q, rec_en_d;
    logic             play_en_q, play_en_d;
    logic             clr_q, clr_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       rec_len_q, rec_len_d;
    logic [TickW-1:0] tick_q, tick_d;
    logic             restart, advance;

    always_comb begin
        state_d   = state_q;
        rec_len_d = rec_len_q;
        sec_d     = sec_q;
        tick_d    = tick_q;
        clr_d     = 1'b0;
        restart   = 1'b0;
        advance   = 1'b0;

        // Priority inside each state: stop > done > pause > start.
        unique case (state_q)
            StIdle: begin
                if (ctrl_io.i_key_start) begin
                    if (!ctrl_io.i_sel_play) begin
                        state_d = StRec;
                        restart = 1'b1;
                    end else if (rec_len_q != '0) begin
                        state_d = StPlay;
                        restart = 1'b1;
                    end
                end
            end
            StRec: begin
                if (ctrl_io.i_key_stop || ctrl_io.i_done || (sec_q == MaxSec)) begin
                    state_d   = StIdle;
                    rec_len_d = sec_q;
                end else if (ctrl_io.i_key_pause) begin
                    state_d = StPauseRec;
                end else begin
                    advance = 1'b1;
                end
            end
            StPlay: begin
                if (ctrl_io.i_key_stop) begin
                    state_d = StIdle;
                end else if (ctrl_io.i_done) begin
`ifdef LOOP_PLAY_EN
                    restart = 1'b1;
`else
                    state_d = StIdle;
`endif
                end else if (ctrl_io.i_key_pause) begin
                    state_d = StPausePlay;
                end else begin
                    advance = 1'b1;
                end
            end
            StPauseRec: begin
                if (ctrl_io.i_key_stop) begin
                    state_d   = StIdle;
                    rec_len_d = sec_q;
                end else if (ctrl_io.i_key_start) begin
                    state_d = StRec;
                end
            end
            StPausePlay: begin
                if (ctrl_io.i_key_stop) begin
                    state_d = StIdle;
                end else if (ctrl_io.i_key_start) begin
                    state_d = StPlay;
                end
            end
            default: state_d = StIdle;
        endcase

        // Time only accrues on cycles that stay running, so a latched length matches o_sec.
        if (restart) begin
            clr_d  = 1'b1;
            sec_d  = '0;
            tick_d = '0;
        end else if (advance) begin
            if (tick_q == TickMax) begin
                tick_d = '0;
                if (sec_q != MaxSec) begin
                    sec_d = sec_q + 6'd1;
                end
            end else begin
                tick_d = tick_q + 1'b1;
            end
        end
    end

    always_comb begin
        mode_d    = 3'b000;
        rec_en_d  = 1'b0;
        play_en_d = 1'b0;
        unique case (state_d)
            StRec: begin
                mode_d   = 3'b001;
                rec_en_d = 1'b1;
            end
            StPlay: begin
                mode_d    = 3'b010;
                play_en_d = 1'b1;
            end
            StPauseRec, StPausePlay: mode_d = 3'b100;
            default: mode_d = 3'b000;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= StIdle;
            mode_q    <= 3'b000;
            rec_en_q  <= 1'b0;
            play_en_q <= 1'b0;
            clr_q     <= 1'b0;
            sec_q     <= '0;
            rec_len_q <= '0;
            tick_q    <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            rec_en_q  <= rec_en_d;
            play_en_q <= play_en_d;
            clr_q     <= clr_d;
            sec_q     <= sec_d;
            rec_len_q <= rec_len_d;
            tick_q    <= tick_d;
        end
    end

    assign ctrl_io.o_mode    = mode_q;
    assign ctrl_io.o_rec_en  = rec_en_q;
    assign ctrl_io.o_play_en = play_en_q;
    assign ctrl_io.o_clr     = clr_q;
    assign ctrl_io.o_sec     = sec_q;
    assign ctrl_io.o_rec_len = rec_len_q;
endmodule

// File: tb/tb_audio_mode_ctrl.sv
// Directed bench for audio_mode_ctrl with a 4-cycle second and a 3-second capacity.
module tb_audio_mode_ctrl;
    logic i_clk;
    logic i_rst_n;
    int   n_cmp;
    int   n_err;

    audio_mode_ctrl_if bus ();

    audio_mode_ctrl #(
        .CLK_FREQ(4),
        .MAX_SEC (3)
    ) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .ctrl_io(bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Advance n rising edges, then settle 1 time unit past the last edge.
    task automatic step(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_mode"},    32'(bus.o_mode),    32'h0);
        chk({tag, "_rec_en"},  32'(bus.o_rec_en),  32'h0);
        chk({tag, "_play_en"}, 32'(bus.o_play_en), 32'h0);
        chk({tag, "_clr"},     32'(bus.o_clr),     32'h0);
        chk({tag, "_sec"},     32'(bus.o_sec),     32'h0);
        chk({tag, "_rec_len"}, 32'(bus.o_rec_len), 32'h0);
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        i_rst_n         = 1'b0;
        bus.i_key_start = 1'b0;
        bus.i_key_pause = 1'b0;
        bus.i_key_stop  = 1'b0;
        bus.i_sel_play  = 1'b0;
        bus.i_done      = 1'b0;
        step(2);
        i_rst_n = 1'b1;
        step(1);
        chk_idle_reset("reset");

        // Play request with nothing recorded is refused.
        bus.i_sel_play = 1'b1; bus.i_key_start = 1'b1; step(1); bus.i_key_start = 1'b0;
        chk("play_empty_mode", 32'(bus.o_mode), 32'h0);
        chk("play_empty_clr",  32'(bus.o_clr),  32'h0);

        // Record until capacity: o_sec hits 3 at edge 12, auto-stop at edge 13.
        bus.i_sel_play = 1'b0; bus.i_key_start = 1'b1; step(1); bus.i_key_start = 1'b0;
        chk("rec_mode",   32'(bus.o_mode),   32'h1);
        chk("rec_en",     32'(bus.o_rec_en), 32'h1);
        chk("rec_clr",    32'(bus.o_clr),    32'h1);
        chk("rec_sec0",   32'(bus.o_sec),    32'h0);
        step(1);
        chk("rec_clr_1cyc", 32'(bus.o_clr), 32'h0);
        step(11);
        chk("full_sec",    32'(bus.o_sec),    32'h3);
        chk("full_mode",   32'(bus.o_mode),   32'h1);
        step(1);
        chk("auto_mode",    32'(bus.o_mode),    32'h0);
        chk("auto_rec_en",  32'(bus.o_rec_en),  32'h0);
        chk("auto_rec_len", 32'(bus.o_rec_len), 32'h3);
        chk("auto_sec",     32'(bus.o_sec),     32'h3);

        // Record 8 cycles then stop: length 2.
        bus.i_key_start = 1'b1; step(1); bus.i_key_start = 1'b0;
        chk("rec2_clr", 32'(bus.o_clr), 32'h1);
        step(8);
        chk("rec2_sec", 32'(bus.o_sec), 32'h2);
        bus.i_key_stop = 1'b1; step(1); bus.i_key_stop = 1'b0;
        chk("stop_mode",    32'(bus.o_mode),    32'h0);
        chk("stop_rec_en",  32'(bus.o_rec_en),  32'h0);
        chk("stop_rec_len", 32'(bus.o_rec_len), 32'h2);
        chk("stop_sec",     32'(bus.o_sec),     32'h2);

        // Play, pause 10 cycles, resume: tick kept (1 of 4), no clear on resume.
        bus.i_sel_play = 1'b1; bus.i_key_start = 1'b1; step(1); bus.i_key_start = 1'b0;
        chk("play_mode", 32'(bus.o_mode),    32'h2);
        chk("play_en",   32'(bus.o_play_en), 32'h1);
        chk("play_clr",  32'(bus.o_clr),     32'h1);
        chk("play_sec0", 32'(bus.o_sec),     32'h0);
        step(5);
        chk("play_sec1", 32'(bus.o_sec), 32'h1);
        bus.i_key_pause = 1'b1; step(1); bus.i_key_pause = 1'b0;
        chk("ppause_mode", 32'(bus.o_mode),    32'h4);
        chk("ppause_en",   32'(bus.o_play_en), 32'h0);
        bus.i_done = 1'b1; step(1); bus.i_done = 1'b0;
        chk("ppause_done_mode", 32'(bus.o_mode), 32'h4);
        step(9);
        chk("ppause_sec", 32'(bus.o_sec), 32'h1);
        bus.i_key_start = 1'b1; step(1); bus.i_key_start = 1'b0;
        chk("resume_mode", 32'(bus.o_mode),    32'h2);
        chk("resume_en",   32'(bus.o_play_en), 32'h1);
        chk("resume_clr",  32'(bus.o_clr),     32'h0);
        step(2);
        chk("resume_sec_hold", 32'(bus.o_sec), 32'h1);
        step(1);
        chk("resume_sec_inc", 32'(bus.o_sec), 32'h2);

        // pause + done together in PLAY: done wins.
        bus.i_key_pause = 1'b1; bus.i_done = 1'b1; step(1);
        bus.i_key_pause = 1'b0; bus.i_done = 1'b0;
`ifdef LOOP_PLAY_EN
        chk("pd_mode", 32'(bus.o_mode), 32'h2);
        chk("pd_clr",  32'(bus.o_clr),  32'h1);
        chk("pd_sec",  32'(bus.o_sec),  32'h0);
        bus.i_key_stop = 1'b1; step(1); bus.i_key_stop = 1'b0;
        chk("pd_stop_mode", 32'(bus.o_mode), 32'h0);
`else
        chk("pd_mode",    32'(bus.o_mode),    32'h0);
        chk("pd_play_en", 32'(bus.o_play_en), 32'h0);
        chk("pd_sec",     32'(bus.o_sec),     32'h2);
`endif

        // Record, pause, stop from pause latches the length.
        bus.i_sel_play = 1'b0; bus.i_key_start = 1'b1; step(1); bus.i_key_start = 1'b0;
        step(4);
        bus.i_key_pause = 1'b1; step(1); bus.i_key_pause = 1'b0;
        chk("rpause_mode",   32'(bus.o_mode),   32'h4);
        chk("rpause_rec_en", 32'(bus.o_rec_en), 32'h0);
        bus.i_key_stop = 1'b1; step(1); bus.i_key_stop = 1'b0;
        chk("rpause_stop_mode", 32'(bus.o_mode),    32'h0);
        chk("rpause_rec_len",   32'(bus.o_rec_len), 32'h1);

        // Reset in the middle of a recording clears everything, including the length.
        bus.i_key_start = 1'b1; step(1); bus.i_key_start = 1'b0;
        step(5);
        chk("prereset_sec", 32'(bus.o_sec), 32'h1);
        i_rst_n = 1'b0; step(1);
        chk_idle_reset("midreset");
        i_rst_n = 1'b1; step(1);

        // start + stop together in REC: stop wins.
        bus.i_key_start = 1'b1; step(1); bus.i_key_start = 1'b0;
        step(5);
        bus.i_key_start = 1'b1; bus.i_key_stop = 1'b1; step(1);
        bus.i_key_start = 1'b0; bus.i_key_stop = 1'b0;
        chk("ss_mode",    32'(bus.o_mode),    32'h0);
        chk("ss_rec_en",  32'(bus.o_rec_en),  32'h0);
        chk("ss_clr",     32'(bus.o_clr),     32'h0);
        chk("ss_rec_len", 32'(bus.o_rec_len), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
